rr_arbiter8: RTL and testbench

RR_ARBITER8 -- requirements
Module: rr_arbiter8

---
 rtl/arb_pkg.sv | 29 ++
 rtl/rr_pick8.sv | 37 +++
 rtl/rr_arbiter8.sv | 121 ++++++++++++
 tb/tb_rr_arbiter8.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pkg
//  Description : Shared constants, state encoding and helpers for the
//                8-way round-robin arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package arb_pkg;

   localparam int c_NUM_REQ = 8;
   localparam int c_IDX_W   = 3;
   localparam int c_CNT_W   = 8;

   // Arbiter state: no grant outstanding, or a grant being held.
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arbState_t;

   // Binary index to one-hot grant vector.
   function automatic logic [c_NUM_REQ-1:0] oneHot8(input logic [c_IDX_W-1:0] idx);
      logic [c_NUM_REQ-1:0] vec;
      vec      = '0;
      vec[idx] = 1'b1;
      return vec;
   endfunction

endpackage : arb_pkg
`default_nettype wire

// File: rtl/rr_pick8.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick8
//  Description : Combinational rotating-priority picker. Returns the first
//                set request bit at or after the pointer, wrapping 7 -> 0.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick8
   import arb_pkg::*;
(
   input  logic [c_NUM_REQ-1:0] i_req,
   input  logic [c_IDX_W-1:0]   i_ptr,
   output logic [c_IDX_W-1:0]   o_idx,
   output logic                 o_anyValid
);

   logic [c_IDX_W-1:0] w_pos;
   logic               w_found;

   // Scan the eight positions starting at the pointer; first hit wins.
   always_comb begin
      o_idx   = '0;
      w_found = 1'b0;
      w_pos   = '0;
      for (int k = 0; k < c_NUM_REQ; k++) begin
         w_pos = i_ptr + c_IDX_W'(k);
         if (!w_found && i_req[w_pos]) begin
            o_idx   = w_pos;
            w_found = 1'b1;
         end
      end
   end

   assign o_anyValid = |i_req;

endmodule : rr_pick8
`default_nettype wire

// File: rtl/rr_arbiter8.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter8
//  Description : 8-requester round-robin arbiter with registered one-hot
//                grant, owner release pulse, request-drop release and a
//                hold-length limit that forces release with a timeout flag.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter8
   import arb_pkg::*;
#(
   parameter int HOLD_MAX = 16
)(
   input  logic                 iClk,
   input  logic                 iRst_n,
   input  logic [c_NUM_REQ-1:0] iReq,
   input  logic                 iDone,
   output logic [c_NUM_REQ-1:0] oGnt,
   output logic [c_IDX_W-1:0]   oGntIdx,
   output logic                 oValid,
   output logic                 oTimeout
);

   // Last counter value of a grant; reaching it ends the grant at the next edge.
   localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(HOLD_MAX - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_SAT   = '1;

   arbState_t            r_state;
   arbState_t            w_stateNxt;
   logic [c_IDX_W-1:0]   r_ptr;
   logic [c_IDX_W-1:0]   w_ptrNxt;
   logic [c_CNT_W-1:0]   r_holdCnt;
   logic [c_CNT_W-1:0]   w_holdCntNxt;
   logic [c_NUM_REQ-1:0] w_gntNxt;
   logic [c_IDX_W-1:0]   w_idxNxt;
   logic                 w_validNxt;
   logic                 w_timeoutNxt;

   logic [c_IDX_W-1:0]   w_pickIdx;
   logic                 w_pickAny;
   logic                 w_reqHeld;
   logic                 w_holdHit;
   logic                 w_release;

   rr_pick8 uPick (
      .i_req      (iReq),
      .i_ptr      (r_ptr),
      .o_idx      (w_pickIdx),
      .o_anyValid (w_pickAny)
   );

   assign w_reqHeld = iReq[oGntIdx];
   assign w_holdHit = (r_holdCnt == c_HOLD_LAST);
   assign w_release = iDone || !w_reqHeld || w_holdHit;

   // Next-state and next-output decode. The timeout flag is registered at the
   // release edge, so it is seen in the first idle cycle after a forced release.
   always_comb begin
      w_stateNxt   = r_state;
      w_ptrNxt     = r_ptr;
      w_holdCntNxt = r_holdCnt;
      w_gntNxt     = oGnt;
      w_idxNxt     = oGntIdx;
      w_validNxt   = oValid;
      w_timeoutNxt = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_pickAny) begin
               w_stateNxt   = BUSY;
               w_gntNxt     = oneHot8(w_pickIdx);
               w_idxNxt     = w_pickIdx;
               w_validNxt   = 1'b1;
               w_holdCntNxt = '0;
            end
         end
         BUSY: begin
            if (w_release) begin
               w_stateNxt   = IDLE;
               w_gntNxt     = '0;
               w_idxNxt     = '0;
               w_validNxt   = 1'b0;
               w_ptrNxt     = oGntIdx + c_IDX_W'(1);
               w_holdCntNxt = '0;
               w_timeoutNxt = w_holdHit && !iDone && w_reqHeld;
            end else if (r_holdCnt != c_CNT_SAT) begin
               w_holdCntNxt = r_holdCnt + c_CNT_W'(1);
            end
         end
         default: begin
            w_stateNxt   = IDLE;
            w_gntNxt     = '0;
            w_idxNxt     = '0;
            w_validNxt   = 1'b0;
            w_holdCntNxt = '0;
         end
      endcase
   end

   // State, pointer, counter and all outputs live in flops; reset clears them at once.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         r_state   <= IDLE;
         r_ptr     <= '0;
         r_holdCnt <= '0;
         oGnt      <= '0;
         oGntIdx   <= '0;
         oValid    <= 1'b0;
         oTimeout  <= 1'b0;
      end else begin
         r_state   <= w_stateNxt;
         r_ptr     <= w_ptrNxt;
         r_holdCnt <= w_holdCntNxt;
         oGnt      <= w_gntNxt;
         oGntIdx   <= w_idxNxt;
         oValid    <= w_validNxt;
         oTimeout  <= w_timeoutNxt;
      end
   end

endmodule : rr_arbiter8
`default_nettype wire

// File: tb/tb_rr_arbiter8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arbiter8
//  Description : Self-checking bench for rr_arbiter8. Inputs are driven on
//                the falling edge; the expected registered outputs after the
//                following rising edge are queued and compared just after it.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rr_arbiter8;

   logic       iClk;
   logic       iRst_n;
   logic [7:0] iReq;
   logic       iDone;
   logic [7:0] oGnt;
   logic [2:0] oGntIdx;
   logic       oValid;
   logic       oTimeout;

   int nChecks = 0;
   int nPass   = 0;

   typedef struct {
      logic [7:0] req;
      logic       done;
      logic [7:0] gnt;
      logic [2:0] idx;
      logic       valid;
      logic       timeout;
   } vec_t;

   typedef struct {
      string      name;
      logic [7:0] gnt;
      logic [2:0] idx;
      logic       valid;
      logic       timeout;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[21];

   rr_arbiter8 #(.HOLD_MAX(16)) dut (
      .iClk     (iClk),
      .iRst_n   (iRst_n),
      .iReq     (iReq),
      .iDone    (iDone),
      .oGnt     (oGnt),
      .oGntIdx  (oGntIdx),
      .oValid   (oValid),
      .oTimeout (oTimeout)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   task automatic checkOut(input exp_t e);
      nChecks++;
      if (oGnt === e.gnt && oGntIdx === e.idx && oValid === e.valid && oTimeout === e.timeout) begin
         nPass++;
      end else begin
         $display("FAIL %s: got gnt=%h idx=%0d valid=%b timeout=%b, want gnt=%h idx=%0d valid=%b timeout=%b",
                  e.name, oGnt, oGntIdx, oValid, oTimeout, e.gnt, e.idx, e.valid, e.timeout);
      end
   endtask

   // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
   task automatic apply(input string nm, input logic [7:0] req, input logic done,
                        input logic [7:0] gnt, input logic [2:0] idx,
                        input logic valid, input logic timeout);
      exp_t e;
      @(negedge iClk);
      iReq  = req;
      iDone = done;
      e.name = nm; e.gnt = gnt; e.idx = idx; e.valid = valid; e.timeout = timeout;
      sb.push_back(e);
   endtask

   // Scoreboard consumer: one queued expectation per driven cycle.
   always @(posedge iClk) begin
      #1;
      if (sb.size() > 0) checkOut(sb.pop_front());
   end

   task automatic drain();
      @(posedge iClk);
      #2;
   endtask

   exp_t zeroExp;

   initial begin
      // Round-robin alternation, mid-grant request change and wrap,
      // request-drop release, iDone ignored in IDLE, idle with no request.
      tbl[0]  = '{8'h81, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0};
      tbl[1]  = '{8'h81, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0};
      tbl[2]  = '{8'h81, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
      tbl[3]  = '{8'h81, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
      tbl[4]  = '{8'h81, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
      tbl[5]  = '{8'h81, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
      tbl[6]  = '{8'h81, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0};
      tbl[7]  = '{8'h81, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
      tbl[8]  = '{8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0};
      tbl[9]  = '{8'h0C, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0};
      tbl[10] = '{8'h0C, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
      tbl[11] = '{8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0};
      tbl[12] = '{8'h04, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
      tbl[13] = '{8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0};
      tbl[14] = '{8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0};
      tbl[15] = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
      tbl[16] = '{8'hC1, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0};
      tbl[17] = '{8'hC1, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
      tbl[18] = '{8'hC1, 1'b1, 8'h80, 3'd7, 1'b1, 1'b0};
      tbl[19] = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
      tbl[20] = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};

      zeroExp.gnt = 8'h00; zeroExp.idx = 3'd0; zeroExp.valid = 1'b0; zeroExp.timeout = 1'b0;

      iRst_n = 1'b0;
      iReq   = 8'h00;
      iDone  = 1'b0;
      repeat (3) @(posedge iClk);
      #2;
      zeroExp.name = "reset_state";
      checkOut(zeroExp);
      @(negedge iClk);
      iRst_n = 1'b1;

      for (int i = 0; i < 21; i++) begin
         apply($sformatf("vec%0d", i), tbl[i].req, tbl[i].done,
               tbl[i].gnt, tbl[i].idx, tbl[i].valid, tbl[i].timeout);
      end

      // Hold limit: pointer is 0, so requester 4 holds for 16 cycles, then a
      // forced release flags timeout, one bubble, and requester 4 is regranted.
      for (int c = 1; c <= 16; c++)
         apply($sformatf("hold_c%0d", c), 8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0);
      apply("hold_release", 8'h10, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
      apply("hold_regrant", 8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0);

      // iDone coinciding with the hold limit is an ordinary release.
      for (int c = 2; c <= 16; c++)
         apply($sformatf("coinc_c%0d", c), 8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0);
      apply("coinc_release", 8'h10, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);

      // Pointer is now 5: requester 6 wins, then reset is pulsed mid-grant.
      apply("pre_rst_grant", 8'h40, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0);
      apply("pre_rst_hold",  8'h40, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0);
      drain();
      #1;
      iRst_n = 1'b0;
      #1;
      zeroExp.name = "rst_async";
      checkOut(zeroExp);
      iReq = 8'hFF;
      @(posedge iClk);
      #1;
      zeroExp.name = "rst_held";
      checkOut(zeroExp);
      @(negedge iClk);
      iReq   = 8'h00;
      iRst_n = 1'b1;
      apply("post_rst_grant", 8'hFF, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
      apply("post_rst_done",  8'hFF, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
      apply("post_rst_next",  8'hFF, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0);
      drain();

      nChecks++;
      if (sb.size() == 0) nPass++;
      else $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule : tb_rr_arbiter8
`default_nettype wire
